// File: rtl/scene_fade_ctrl_pkg.sv
// Shared types for the scene sequencer: FSM states, packed pixel struct and level sizing.
package scene_pkg;

  typedef enum logic [2:0] {
    MENU,
    FADE_OUT,
    HOLD,
    START_MAIN,
    FADE_IN,
    RUN
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] b;
    logic [7:0] g;
  } rgb_t;

  // Level spans 0..fade_steps inclusive, so one bit more than log2.
  function automatic int level_width(input int fade_steps);
    return $clog2(fade_steps) + 1;
  endfunction

endpackage

// File: rtl/scene_fade_ctrl_color_scaler.sv
// Combinational per-channel brightness scaling: (c * level) >> SHIFT.
module color_scaler
  import scene_pkg::*;
#(
  parameter int LW    = 5,
  parameter int SHIFT = 4
) (
  input  rgb_t            color,
  input  logic [LW-1:0]   level,
  output rgb_t            scaled
);

  logic [23:0] color_flat;
  logic [23:0] scaled_flat;

  assign color_flat = color;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [8+LW-1:0] prod;
      assign prod = {{LW{1'b0}}, color_flat[gi*8 +: 8]} * {8'b0, level};
      // level never exceeds 2**SHIFT, so the shifted product always fits in 8 bits.
      assign scaled_flat[gi*8 +: 8] = 8'(prod >> SHIFT);
    end
  endgenerate

  assign scaled = scaled_flat;

endmodule

// File: rtl/scene_fade_ctrl.sv
// Menu -> black -> game scene sequencer with fade, start handshake and final pixel mux.
module scene_fade_ctrl
  import scene_pkg::*;
#(
  parameter int          FADE_STEPS      = 16,
  parameter int          FRAMES_PER_STEP = 2,
  parameter int          HOLD_FRAMES     = 60,
  parameter logic [23:0] BG_COLOR        = 24'h00FFFF
) (
  input  logic        i_clk_pix,
  input  logic        i_rst_n,
  input  logic        i_frame,
  input  logic        i_start,
  input  logic        i_main_ready,
  input  logic        i_menu_drawing,
  input  logic [23:0] i_menu_color,
  input  logic        i_main_drawing,
  input  logic [23:0] i_main_color,
  output logic        o_main_start,
  output logic        o_menu_active,
  output logic [4:0]  o_fade_level,
  output logic [7:0]  o_red,
  output logic [7:0]  o_blue,
  output logic [7:0]  o_green
);

  localparam int LW    = level_width(FADE_STEPS);
  localparam int SHIFT = $clog2(FADE_STEPS);
  localparam int SCW   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int HCW   = $clog2(HOLD_FRAMES + 1);
  localparam logic [LW-1:0]  LVL_MAX  = LW'(FADE_STEPS);
  localparam logic [SCW-1:0] STEP_END = SCW'(FRAMES_PER_STEP - 1);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(HOLD_FRAMES);
  localparam logic [HCW-1:0] HOLD_END = HCW'(HOLD_FRAMES - 1);

  state_t          state_reg, state_next;
  logic [LW-1:0]   level_reg, level_next;
  logic [SCW-1:0]  step_cnt_reg, step_cnt_next;
  logic [HCW-1:0]  hold_cnt_reg, hold_cnt_next;
  logic            start_q_reg;
  logic            main_start_reg;
  rgb_t            color_reg;

  logic            start_rise;
  logic            tick;
  logic            use_main;
  rgb_t            src_color;
  rgb_t            scaled_color;

  assign start_rise = i_start && !start_q_reg;
  assign tick       = i_frame && (step_cnt_reg == STEP_END);

  always_comb begin
    state_next    = state_reg;
    level_next    = level_reg;
    step_cnt_next = step_cnt_reg;
    hold_cnt_next = hold_cnt_reg;

    case (state_reg)
      MENU: begin
        level_next = LVL_MAX;
        if (start_rise) state_next = FADE_OUT;
      end
      FADE_OUT: begin
        if (tick) begin
          level_next = level_reg - 1'b1;
          if (level_reg == LW'(1)) state_next = HOLD;
        end
      end
      HOLD: begin
        level_next = '0;
        if (i_frame && (hold_cnt_reg >= HOLD_END) && i_main_ready) state_next = START_MAIN;
      end
      START_MAIN: begin
        level_next = '0;
        state_next = FADE_IN;
      end
      FADE_IN: begin
        if (tick) begin
          level_next = level_reg + 1'b1;
          if (level_reg == LVL_MAX - 1'b1) state_next = RUN;
        end
      end
      RUN: begin
        level_next = LVL_MAX;
      end
      default: begin
        state_next = MENU;
        level_next = LVL_MAX;
      end
    endcase

    // A frame strobe landing on a state entry is swallowed by the clear.
    if (state_next != state_reg) begin
      step_cnt_next = '0;
      hold_cnt_next = '0;
    end else begin
      if (tick)         step_cnt_next = '0;
      else if (i_frame) step_cnt_next = step_cnt_reg + 1'b1;
      if (state_reg == HOLD && i_frame && hold_cnt_reg != HOLD_MAX)
        hold_cnt_next = hold_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      state_reg      <= MENU;
      level_reg      <= LVL_MAX;
      step_cnt_reg   <= '0;
      hold_cnt_reg   <= '0;
      start_q_reg    <= 1'b1;
      main_start_reg <= 1'b0;
      color_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      level_reg      <= level_next;
      step_cnt_reg   <= step_cnt_next;
      hold_cnt_reg   <= hold_cnt_next;
      start_q_reg    <= i_start;
      main_start_reg <= (state_next == START_MAIN);
      color_reg      <= scaled_color;
    end
  end

  assign use_main  = (state_reg == START_MAIN) || (state_reg == FADE_IN) || (state_reg == RUN);
  assign src_color = use_main ? (i_main_drawing ? rgb_t'(i_main_color) : rgb_t'(BG_COLOR))
                              : (i_menu_drawing ? rgb_t'(i_menu_color) : rgb_t'(BG_COLOR));

  color_scaler #(
    .LW    (LW),
    .SHIFT (SHIFT)
  ) u_scaler (
    .color  (src_color),
    .level  (level_reg),
    .scaled (scaled_color)
  );

  assign o_main_start  = main_start_reg;
  assign o_menu_active = (state_reg == MENU) || (state_reg == FADE_OUT);
  assign o_fade_level  = 5'(level_reg);
  assign o_red         = color_reg.r;
  assign o_blue        = color_reg.b;
  assign o_green       = color_reg.g;

endmodule

// File: tb/tb_scene_fade_ctrl.sv
// Directed bench for scene_fade_ctrl: fade out, hold, start handshake, fade in, reset mid-fade.
module tb_scene_fade_ctrl;

  logic        clk;
  logic        rst_n;
  logic        frame;
  logic        start;
  logic        main_ready;
  logic        menu_drawing;
  logic [23:0] menu_color;
  logic        main_drawing;
  logic [23:0] main_color;
  logic        main_start;
  logic        menu_active;
  logic [4:0]  fade_level;
  logic [7:0]  red, blue, green;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  scene_fade_ctrl dut (
    .i_clk_pix      (clk),
    .i_rst_n        (rst_n),
    .i_frame        (frame),
    .i_start        (start),
    .i_main_ready   (main_ready),
    .i_menu_drawing (menu_drawing),
    .i_menu_color   (menu_color),
    .i_main_drawing (main_drawing),
    .i_main_color   (main_color),
    .o_main_start   (main_start),
    .o_menu_active  (menu_active),
    .o_fade_level   (fade_level),
    .o_red          (red),
    .o_blue         (blue),
    .o_green        (green)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (main_start) pulses++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame strobe followed by one idle cycle so the pixel register sees the new level.
  task automatic do_frames(input int n, input bit toggle_start);
    for (int i = 0; i < n; i++) begin
      if (toggle_start) start = ~start;
      frame = 1'b1;
      step();
      frame = 1'b0;
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; frame = 1'b0; start = 1'b0; main_ready = 1'b0;
    menu_drawing = 1'b0; menu_color = '0; main_drawing = 1'b0; main_color = '0;
    step(); step();
    check_val("rst_level", 32'(fade_level), 32'd16);
    check_val("rst_rgb", 32'({red, blue, green}), 32'h0);
    check_val("rst_menu_active", 32'(menu_active), 32'd1);
    check_val("rst_main_start", 32'(main_start), 32'd0);
    rst_n = 1'b1;
    step();

    // Menu passthrough and backdrop
    menu_drawing = 1'b1; menu_color = 24'h123456;
    step();
    check_val("menu_pass", 32'({red, blue, green}), 32'h123456);
    check_val("menu_level", 32'(fade_level), 32'd16);
    check_val("menu_start_lo", 32'(main_start), 32'd0);
    menu_drawing = 1'b0;
    step();
    check_val("menu_bg", 32'({red, blue, green}), 32'h00FFFF);

    // Fade out
    menu_drawing = 1'b1; menu_color = 24'hFFFFFF;
    start = 1'b1;
    step();
    do_frames(16, 1'b0);
    check_val("fo_half_level", 32'(fade_level), 32'd8);
    check_val("fo_half_rgb", 32'({red, blue, green}), 32'h7F7F7F);
    check_val("fo_half_active", 32'(menu_active), 32'd1);
    do_frames(16, 1'b0);
    check_val("fo_end_level", 32'(fade_level), 32'd0);
    check_val("fo_end_rgb", 32'({red, blue, green}), 32'h0);
    check_val("hold_menu_active", 32'(menu_active), 32'd0);

    // Hold without main ready
    do_frames(200, 1'b0);
    check_val("hold_rgb", 32'({red, blue, green}), 32'h0);
    check_val("hold_no_pulse", 32'(pulses), 32'd0);
    main_ready = 1'b1;
    step();
    check_val("ready_wait_frame", 32'(main_start), 32'd0);
    frame = 1'b1;
    step();
    frame = 1'b0;
    check_val("start_pulse_hi", 32'(main_start), 32'd1);
    step();
    check_val("start_pulse_lo", 32'(main_start), 32'd0);
    check_val("pulse_count_1", 32'(pulses), 32'd1);

    // Fade in, with start toggling throughout
    main_drawing = 1'b1; main_color = 24'h808080;
    do_frames(8, 1'b1);
    check_val("fi_l4_level", 32'(fade_level), 32'd4);
    check_val("fi_l4_rgb", 32'({red, blue, green}), 32'h202020);
    do_frames(24, 1'b1);
    check_val("run_level", 32'(fade_level), 32'd16);
    check_val("run_rgb", 32'({red, blue, green}), 32'h808080);
    do_frames(10, 1'b1);
    check_val("run_stays_level", 32'(fade_level), 32'd16);
    check_val("run_menu_active", 32'(menu_active), 32'd0);
    check_val("run_no_extra_pulse", 32'(pulses), 32'd1);

    // Reset mid fade-out with start held high
    rst_n = 1'b0; step(); rst_n = 1'b1;
    start = 1'b0; step();
    start = 1'b1; step();
    do_frames(14, 1'b0);
    check_val("fo2_level9", 32'(fade_level), 32'd9);
    rst_n = 1'b0;
    step();
    check_val("midrst_level", 32'(fade_level), 32'd16);
    check_val("midrst_rgb", 32'({red, blue, green}), 32'h0);
    check_val("midrst_active", 32'(menu_active), 32'd1);
    rst_n = 1'b1;
    do_frames(6, 1'b0);
    check_val("held_start_level", 32'(fade_level), 32'd16);
    check_val("held_start_rgb", 32'({red, blue, green}), 32'hFFFFFF);
    check_val("final_pulse_count", 32'(pulses), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scene_fade_ctrl.md
Name: scene_fade_ctrl

Overview:
Top-level scene sequencer between the menu renderer and the main game renderer. It detects the start request, fades the menu to black, and holds black until the main game is ready. It then pulses the main-start handshake and fades the game image in. It owns the final pixel mux and the brightness scaling, and drives the VGA color outputs.

Parameters:
FADE_STEPS, 16, brightness levels; must be a power of 2; fade level range is 0..FADE_STEPS.
FRAMES_PER_STEP, 2, i_frame pulses per fade-level step.
HOLD_FRAMES, 60, minimum black frames between fade-out and main start.
BG_COLOR, 24'h00FFFF, backdrop when no source pixel is drawing.

Ports:
i_clk_pix  in  1  pixel clock
i_rst_n  in  1  synchronous active-low reset
i_frame  in  1  one-cycle start-of-frame strobe
i_start  in  1  start request level (active-high key)
i_main_ready  in  1  main game initialised, level
i_menu_drawing  in  1  menu pixel valid (already trans-masked)
i_menu_color  in  24  menu pixel, packed {red, blue, green}
i_main_drawing  in  1  game pixel valid
i_main_color  in  24  game pixel, packed {red, blue, green}
o_main_start  out  1  one-cycle start pulse to main game
o_menu_active  out  1  menu owns the screen (states MENU, FADE_OUT)
o_fade_level  out  5  current brightness level
o_red, o_blue, o_green  out  8 each  registered scaled color

Behaviour:
- Reset is synchronous and active-low on i_clk_pix. It takes effect at any state, including mid-fade. Reset values:
  - state MENU, level=FADE_STEPS, step_cnt=0, hold_cnt=0
  - o_main_start=0, o_menu_active=1, color outputs 0
  - start_q=1, so a key held through reset does not trigger a start.
- Start edge: start_rise = i_start && !start_q. start_q registers i_start every cycle.
- Step tick: tick = i_frame && step_cnt==FRAMES_PER_STEP-1.
  - step_cnt increments on i_frame and wraps to 0 at the tick.
  - step_cnt is cleared on every state change.
- State machine:
  - MENU: source is menu; level=FADE_STEPS. On start_rise, go to FADE_OUT.
  - FADE_OUT: source is menu. On each tick, level decrements. The tick with level==1 sets level to 0 and enters HOLD. Fade-out takes FADE_STEPS*FRAMES_PER_STEP frames.
  - HOLD: level=0, so the output is black.
    - hold_cnt increments on i_frame and saturates at HOLD_FRAMES.
    - On i_frame with hold_cnt>=HOLD_FRAMES-1 and i_main_ready=1, go to START_MAIN.
    - If i_main_ready=0, stay in HOLD indefinitely.
  - START_MAIN: o_main_start=1 for exactly this one cycle. Source switches to main. Next state is FADE_IN unconditionally.
  - FADE_IN: source is main. On each tick, level increments. The tick with level==FADE_STEPS-1 sets level to FADE_STEPS and enters RUN.
  - RUN: terminal state; source is main; level=FADE_STEPS. Only reset leaves RUN.
- start_rise outside MENU is ignored. i_main_ready is ignored outside HOLD.
- An i_frame coinciding with a state entry does not count toward the new state.
- o_main_start is registered, asserted only in START_MAIN and never re-asserted without reset.
- Pixel path:
  - src = drawing ? color : BG_COLOR, using the menu or main inputs according to state.
  - Each channel out = (c * level) >> log2(FADE_STEPS), using a 13-bit product.
  - level==FADE_STEPS gives an exact passthrough; level==0 gives 0.
  - Latency is 1 cycle from input pixel to o_* outputs.
  - The level used is the value registered at the same cycle as the sample, so there is no tearing within a cycle.
- o_fade_level mirrors the internal level register.

Decomposition:
- Package scene_pkg holds:
  - state enum {MENU, FADE_OUT, HOLD, START_MAIN, FADE_IN, RUN}
  - rgb_t packed struct {r, b, g}
  - level width function clog2(FADE_STEPS)+1
- Sub-module color_scaler: combinational per-channel multiply-shift of rgb_t by level, instantiated once. The register stage lives in the parent.

Test Plan:
1. Reset, then i_menu_drawing=1, i_menu_color=24'h123456 -> the next cycle after sample shows {o_red,o_blue,o_green}=24'h123456, o_fade_level=16, o_main_start=0. Then i_menu_drawing=0 -> output 24'h00FFFF.
2. i_start rising edge, then i_frame strobes with color 24'hFFFFFF:
   - after 16 frames, level=8 and output 24'h7F7F7F;
   - after 32 frames, level=0 and output 0, state HOLD.
3. HOLD with i_main_ready=0 for 200 frames -> output stays 0 and o_main_start stays 0. Raise i_main_ready -> on the next i_frame, enter START_MAIN and o_main_start is high for exactly 1 cycle.
4. After START_MAIN, i_main_color=24'h808080 drawing:
   - 32 frames -> level=16, RUN, output 24'h808080;
   - at level 4, output 24'h202020.
5. Assert i_rst_n=0 for one cycle while in FADE_OUT at level 9 -> next cycle shows MENU, level 16, color outputs 0. With i_start held high through reset and release -> no transition.
6. Toggle i_start repeatedly in RUN and during FADE_IN -> no state change and no extra o_main_start pulse.
